// File: rtl/store_queue_pkg.sv
// Shared types for the store queue: drain/load FSM states and the queued store entry.
package store_queue_pkg;

  localparam int SQ_DEPTH = 4;
  localparam int SQ_AW    = 14;
  localparam int SQ_DW    = 16;
  localparam int SQ_RW    = 8;

  typedef enum logic [2:0] {
    IDLE,
    ST_REQ,
    LD_WAIT_EMPTY,
    LD_REQ,
    LD_ACK
  } sq_state_t;

  typedef struct packed {
    logic [SQ_AW-1:0] addr;
    logic [SQ_DW-1:0] data;
  } sq_entry_t;

endpackage

// File: rtl/store_queue_fifo.sv
// Circular buffer of posted stores: registered storage, combinational head read,
// power-of-two depth so pointers wrap naturally.
module store_queue_fifo
  import store_queue_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  logic      pop,
  input  sq_entry_t wr_entry,
  output sq_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);

  sq_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW:0]     count_reg;
  logic [PW:0]     count_next;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  // A simultaneous push and pop leaves the count unchanged, even when full.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign full  = (count_reg == (PW+1)'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/store_queue.sv
// Posted-write buffer between the instruction unit and the memory interface: stores are
// acked early and drained in order; loads go out only once every queued store has drained.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH,
  parameter int AW    = SQ_AW,
  parameter int DW    = SQ_DW,
  parameter int RW    = SQ_RW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          iu_store,
  input  logic          iu_load,
  input  logic [AW-1:0] iu_addr,
  input  logic [DW-1:0] iu_result,
  output logic          iu_mem_done,
  output logic [RW-1:0] iu_data,
  output logic          mi_store,
  output logic          mi_load,
  output logic [AW-1:0] mi_addr,
  output logic [DW-1:0] mi_result,
  input  logic          mi_mem_done,
  input  logic [RW-1:0] mi_data,
  output logic          q_full,
  output logic          q_empty
);

  sq_state_t     state_reg, state_next;
  logic          req_seen_reg, req_seen_next;
  logic          load_pending_reg, load_pending_next;
  logic          ack_reg, ack_next;
  logic [RW-1:0] iu_data_reg, iu_data_next;

  logic          push, pop, load_latch, load_done;
  logic          fifo_full, fifo_empty;
  sq_entry_t     wr_entry, head;

  // Entries use the package widths, so AW/DW are expected to stay at SQ_AW/SQ_DW.
  assign wr_entry.addr = iu_addr;
  assign wr_entry.data = iu_result;

  assign pop        = (state_reg == ST_REQ) && mi_mem_done;
  assign load_done  = (state_reg == LD_REQ) && mi_mem_done;
  // A pop in the same cycle frees the slot, so a full queue still accepts the store.
  assign push       = iu_store && !req_seen_reg && !load_pending_reg && (!fifo_full || pop);
  assign load_latch = iu_load && !iu_store && !req_seen_reg && !load_pending_reg;

  store_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    req_seen_next     = req_seen_reg;
    load_pending_next = load_pending_reg;
    ack_next          = push || load_done;
    iu_data_next      = load_done ? mi_data : iu_data_reg;
    // req_seen holds off re-acceptance until the IU drops both requests.
    if (push || load_latch) begin
      req_seen_next = 1'b1;
    end else if (!iu_store && !iu_load) begin
      req_seen_next = 1'b0;
    end
    if (load_latch) begin
      load_pending_next = 1'b1;
    end else if (state_reg == LD_ACK) begin
      load_pending_next = 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    mi_store   = 1'b0;
    mi_load    = 1'b0;
    mi_addr    = '0;
    mi_result  = '0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_REQ;
        end else if (load_pending_reg) begin
          state_next = LD_WAIT_EMPTY;
        end
      end
      ST_REQ: begin
        mi_store  = 1'b1;
        mi_addr   = head.addr;
        mi_result = head.data;
        if (mi_mem_done) begin
          state_next = load_pending_reg ? LD_WAIT_EMPTY : IDLE;
        end
      end
      LD_WAIT_EMPTY: begin
        state_next = fifo_empty ? LD_REQ : ST_REQ;
      end
      LD_REQ: begin
        mi_load = 1'b1;
        mi_addr = iu_addr;
        if (mi_mem_done) begin
          state_next = LD_ACK;
        end
      end
      LD_ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      req_seen_reg     <= 1'b0;
      load_pending_reg <= 1'b0;
      ack_reg          <= 1'b0;
      iu_data_reg      <= '0;
    end else begin
      state_reg        <= state_next;
      req_seen_reg     <= req_seen_next;
      load_pending_reg <= load_pending_next;
      ack_reg          <= ack_next;
      iu_data_reg      <= iu_data_next;
    end
  end

  assign iu_mem_done = ack_reg;
  assign iu_data     = iu_data_reg;
  assign q_full      = fifo_full;
  assign q_empty     = fifo_empty;

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed scenarios plus random store/load traffic checked against
// an in-order store list and a flat memory image kept at the IU's level of abstraction.
module tb_store_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        iu_store;
  logic        iu_load;
  logic [13:0] iu_addr;
  logic [15:0] iu_result;
  logic        iu_mem_done;
  logic [7:0]  iu_data;
  logic        mi_store;
  logic        mi_load;
  logic [13:0] mi_addr;
  logic [15:0] mi_result;
  logic        mi_mem_done;
  logic [7:0]  mi_data;
  logic        q_full;
  logic        q_empty;

  typedef struct {
    logic [13:0] a;
    logic [15:0] d;
  } st_t;

  st_t       exp_q[$];
  bit [15:0] ref_mem [0:16383];
  bit [15:0] sram [0:16383];
  bit        mem_stall = 1'b0;
  int        mem_lat = 1;
  int        total = 0;
  int        bad = 0;

  store_queue dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .iu_store    (iu_store),
    .iu_load     (iu_load),
    .iu_addr     (iu_addr),
    .iu_result   (iu_result),
    .iu_mem_done (iu_mem_done),
    .iu_data     (iu_data),
    .mi_store    (mi_store),
    .mi_load     (mi_load),
    .mi_addr     (mi_addr),
    .mi_result   (mi_result),
    .mi_mem_done (mi_mem_done),
    .mi_data     (mi_data),
    .q_full      (q_full),
    .q_empty     (q_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory-interface model: optional latency, one-cycle completion pulse, flat SRAM image.
  initial begin
    int  lat_cnt;
    st_t e;
    mi_mem_done = 1'b0;
    mi_data     = '0;
    lat_cnt     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mi_load) begin
        check("load_only_when_empty", 32'(q_empty), 32'd1);
      end
      if (mi_mem_done) begin
        mi_mem_done = 1'b0;
      end else if (!mem_stall && (mi_store || mi_load)) begin
        if (lat_cnt < mem_lat) begin
          lat_cnt++;
        end else begin
          lat_cnt     = 0;
          mi_mem_done = 1'b1;
          if (mi_store) begin
            check("drain_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("drain_addr", 32'(mi_addr), 32'(e.a));
              check("drain_data", 32'(mi_result), 32'(e.d));
            end
            sram[mi_addr] = mi_result;
          end else begin
            check("load_after_drain", 32'(exp_q.size()), 32'd0);
            mi_data = sram[mi_addr][7:0];
          end
        end
      end
    end
  end

  task automatic do_store(input logic [13:0] a, input logic [15:0] d, input int budget,
                          output int lat);
    st_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
    ref_mem[a] = d;
    iu_addr    = a;
    iu_result  = d;
    iu_store   = 1'b1;
    lat        = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (iu_mem_done) begin
        lat = i;
        break;
      end
    end
    iu_store = 1'b0;
    check("store_acked", 32'(lat > 0), 32'd1);
    tick();
    check("store_ack_one_cycle", 32'(iu_mem_done), 32'd0);
  endtask

  task automatic do_load(input logic [13:0] a, input int budget);
    logic [7:0] got_data;
    bit         got;
    got      = 1'b0;
    got_data = '0;
    iu_addr  = a;
    iu_load  = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (iu_mem_done) begin
        got      = 1'b1;
        got_data = iu_data;
        break;
      end
    end
    iu_load = 1'b0;
    check("load_acked", 32'(got), 32'd1);
    check("load_data", 32'(got_data), 32'(ref_mem[a][7:0]));
    tick();
    check("load_ack_one_cycle", 32'(iu_mem_done), 32'd0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && !(q_empty && !mi_store && exp_q.size() == 0); i++) begin
      tick();
    end
    repeat (3) tick();
    check({tag, "_empty"}, 32'(q_empty), 32'd1);
    check({tag, "_all_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    st_t         e;
    int          lat;
    int          early;
    bit          got;
    bit          prev_done;
    logic [13:0] a;

    reset_n   = 1'b0;
    iu_store  = 1'b0;
    iu_load   = 1'b0;
    iu_addr   = '0;
    iu_result = '0;
    repeat (3) tick();
    check("rst_iu_mem_done", 32'(iu_mem_done), 32'd0);
    check("rst_iu_data", 32'(iu_data), 32'd0);
    check("rst_mi_store", 32'(mi_store), 32'd0);
    check("rst_mi_load", 32'(mi_load), 32'd0);
    check("rst_mi_addr", 32'(mi_addr), 32'd0);
    check("rst_mi_result", 32'(mi_result), 32'd0);
    check("rst_q_full", 32'(q_full), 32'd0);
    check("rst_q_empty", 32'(q_empty), 32'd1);
    reset_n = 1'b1;
    tick();

    // Single store: ack is high the cycle after the request cycle, i.e. at the IU's second edge.
    mem_lat = 2;
    do_store(14'h0010, 16'hBEEF, 20, lat);
    check("single_ack_latency", 32'(lat), 32'd1);
    for (int i = 0; i < 20 && !mi_store; i++) tick();
    check("single_mi_store", 32'(mi_store), 32'd1);
    check("single_mi_addr", 32'(mi_addr), 32'h0010);
    check("single_mi_result", 32'(mi_result), 32'hBEEF);
    drain("single");

    // Burst of 5 against a stalled memory.
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_store(14'h0020 + 14'(i), 16'h1000 + 16'(i), 20, lat);
      check("burst_ack_latency", 32'(lat), 32'd1);
    end
    check("burst_q_full", 32'(q_full), 32'd1);
    e.a = 14'h0024;
    e.d = 16'h1004;
    exp_q.push_back(e);
    ref_mem[e.a] = e.d;
    iu_addr   = e.a;
    iu_result = e.d;
    iu_store  = 1'b1;
    early = 0;
    repeat (5) begin
      tick();
      if (iu_mem_done) early++;
    end
    check("burst_full_blocks", 32'(early), 32'd0);
    check("burst_still_full", 32'(q_full), 32'd1);
    mem_lat   = 0;
    mem_stall = 1'b0;
    got       = 1'b0;
    prev_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (iu_mem_done) begin
        got = 1'b1;
        break;
      end
      prev_done = mi_mem_done;
    end
    check("burst_fifth_acked", 32'(got), 32'd1);
    check("burst_fifth_after_done", 32'(prev_done), 32'd1);
    iu_store = 1'b0;
    tick();
    drain("burst");

    // Store then load to the same address.
    mem_lat = 3;
    do_store(14'h0030, 16'h00A5, 20, lat);
    do_load(14'h0030, 100);
    check("st_ld_value", 32'(ref_mem[14'h0030][7:0]), 32'h00A5);
    drain("st_ld");

    // Held store request is serviced once; a fresh request is serviced again.
    mem_lat = 1;
    e.a = 14'h0050;
    e.d = 16'h5551;
    exp_q.push_back(e);
    ref_mem[e.a] = e.d;
    iu_addr   = e.a;
    iu_result = e.d;
    iu_store  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (iu_mem_done) begin
        got = 1'b1;
        break;
      end
    end
    check("held_first_ack", 32'(got), 32'd1);
    early = 0;
    repeat (6) begin
      tick();
      if (iu_mem_done) early++;
    end
    check("held_no_reack", 32'(early), 32'd0);
    iu_store = 1'b0;
    tick();
    do_store(14'h0050, 16'h5552, 20, lat);
    drain("held");

    // Reset while a store is being presented to memory.
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) do_store(14'h0040 + 14'(i), 16'h4000 + 16'(i), 20, lat);
    for (int i = 0; i < 20 && !mi_store; i++) tick();
    check("mid_drain_st_req", 32'(mi_store), 32'd1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_mi_store", 32'(mi_store), 32'd0);
    check("mid_rst_q_empty", 32'(q_empty), 32'd1);
    check("mid_rst_iu_mem_done", 32'(iu_mem_done), 32'd0);
    reset_n = 1'b1;
    exp_q.delete();
    mem_stall = 1'b0;
    repeat (3) tick();
    check("post_rst_idle", 32'(mi_store), 32'd0);

    // Spurious completion while idle with an empty queue.
    mem_stall   = 1'b1;
    mi_mem_done = 1'b1;
    tick();
    check("spur_q_empty", 32'(q_empty), 32'd1);
    check("spur_no_ack", 32'(iu_mem_done), 32'd0);
    tick();
    check("spur_no_ack_later", 32'(iu_mem_done), 32'd0);
    check("spur_q_still_empty", 32'(q_empty), 32'd1);
    check("spur_no_mi_store", 32'(mi_store), 32'd0);
    mem_stall = 1'b0;

    // Random store/load traffic over a small address window.
    for (int n = 0; n < 40; n++) begin
      mem_lat = int'($urandom_range(0, 3));
      a = 14'h0100 + 14'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) begin
        do_store(a, 16'($urandom), 100, lat);
      end else begin
        do_load(a, 300);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
